// File: rtl/ps2_keycode_decoder.sv
// ps2_keycode_decoder
//   Turns PS/2 set-2 scan-code bytes into ASCII characters. It tracks the
//   E0/F0/E1 prefixes, the shift and caps-lock state and the make-code
//   mapping. Decoded characters go into a first-word-fall-through FIFO.
// Ports:
//   inclock      - system clock, rising edge
//   resetn       - synchronous active-low reset
//   key_data     - scan-code byte from the PS/2 receiver
//   key_pressed  - byte-available level from the receiver; only its rising edge is used
//   ascii_ready  - consumer pops the head entry when ascii_valid is also high
//   ascii_data   - head-of-FIFO character (0x00 when empty)
//   ascii_valid  - FIFO non-empty
//   fifo_count   - FIFO occupancy
//   shift_active - left or right shift held
//   caps_lock    - caps-lock toggle state
//   overflow     - sticky: a character was dropped on a full FIFO
module ps2_keycode_decoder #(
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic                     inclock,
    input  logic                     resetn,
    input  logic [7:0]               key_data,
    input  logic                     key_pressed,
    input  logic                     ascii_ready,
    output logic [7:0]               ascii_data,
    output logic                     ascii_valid,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count,
    output logic                     shift_active,
    output logic                     caps_lock,
    output logic                     overflow
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, IGN} state_t;

    state_t                     state;
    logic   [2:0]               ign_cnt;
    logic                       key_prev;
    logic                       shift_l;
    logic                       shift_r;
    logic   [7:0]               mem [DEPTH];
    logic   [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic   [FIFO_DEPTH_LOG2-1:0] rd_ptr;

    logic       accept;
    logic       push;
    logic [7:0] push_char;
    logic       full;
    logic       pop;
    logic       do_push;
    logic [8:0] base_hit;
    logic [8:0] ext_hit;

    // Returns {hit, char}. Letters come back in the requested case.
    function automatic logic [8:0] base_map(input logic [7:0] code, input logic upper);
        logic [7:0] c;
        logic       letter;
        c      = 8'h00;
        letter = 1'b1;
        case (code)
            8'h1C: c = "A";  8'h32: c = "B";  8'h21: c = "C";  8'h23: c = "D";
            8'h24: c = "E";  8'h2B: c = "F";  8'h34: c = "G";  8'h33: c = "H";
            8'h43: c = "I";  8'h3B: c = "J";  8'h42: c = "K";  8'h4B: c = "L";
            8'h3A: c = "M";  8'h31: c = "N";  8'h44: c = "O";  8'h4D: c = "P";
            8'h15: c = "Q";  8'h2D: c = "R";  8'h1B: c = "S";  8'h2C: c = "T";
            8'h3C: c = "U";  8'h2A: c = "V";  8'h1D: c = "W";  8'h22: c = "X";
            8'h35: c = "Y";  8'h1A: c = "Z";
            default: letter = 1'b0;
        endcase
        if (letter) begin
            return {1'b1, upper ? c : (c | 8'h20)};
        end
        case (code)
            8'h45: return {1'b1, 8'h30};
            8'h16: return {1'b1, 8'h31};
            8'h1E: return {1'b1, 8'h32};
            8'h26: return {1'b1, 8'h33};
            8'h25: return {1'b1, 8'h34};
            8'h2E: return {1'b1, 8'h35};
            8'h36: return {1'b1, 8'h36};
            8'h3D: return {1'b1, 8'h37};
            8'h3E: return {1'b1, 8'h38};
            8'h46: return {1'b1, 8'h39};
            8'h29: return {1'b1, 8'h20};
            8'h5A: return {1'b1, 8'h0D};
            8'h66: return {1'b1, 8'h08};
            8'h4E: return {1'b1, 8'h2D};
            8'h49: return {1'b1, 8'h2E};
            8'h54: return {1'b1, 8'h5B};
            8'h5B: return {1'b1, 8'h5D};
            default: return 9'h000;
        endcase
    endfunction

    function automatic logic [8:0] ext_map(input logic [7:0] code);
        case (code)
            8'h75:   return {1'b1, 8'h11};
            8'h72:   return {1'b1, 8'h12};
            8'h6B:   return {1'b1, 8'h13};
            8'h74:   return {1'b1, 8'h14};
            8'h5A:   return {1'b1, 8'h0D};
            default: return 9'h000;
        endcase
    endfunction

    assign accept       = key_pressed && !key_prev;
    assign shift_active = shift_l | shift_r;
    assign ascii_valid  = (fifo_count != '0);
    assign ascii_data   = ascii_valid ? mem[rd_ptr] : 8'h00;
    assign full         = (fifo_count == (FIFO_DEPTH_LOG2+1)'(DEPTH));
    assign pop          = ascii_valid && ascii_ready;
    assign do_push      = push && (!full || pop);
    assign base_hit     = base_map(key_data, shift_active ^ caps_lock);
    assign ext_hit      = ext_map(key_data);

    // Prefix bytes and modifiers are absent from both maps, so they never push.
    always_comb begin
        push      = 1'b0;
        push_char = '0;
        if (accept) begin
            if (state == IDLE) begin
                push      = base_hit[8];
                push_char = base_hit[7:0];
            end else if (state == EXT && key_data != 8'hF0) begin
                push      = ext_hit[8];
                push_char = ext_hit[7:0];
            end
        end
    end

    always_ff @(posedge inclock) begin
        if (!resetn) begin
            state     <= IDLE;
            ign_cnt   <= '0;
            key_prev  <= 1'b0;
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            caps_lock <= 1'b0;
        end else begin
            key_prev <= key_pressed;
            if (accept) begin
                case (state)
                    IDLE: begin
                        case (key_data)
                            8'hE0: state <= EXT;
                            8'hF0: state <= BRK;
                            8'hE1: begin
                                state   <= IGN;
                                ign_cnt <= 3'd7;
                            end
                            8'h12: shift_l   <= 1'b1;
                            8'h59: shift_r   <= 1'b1;
                            8'h58: caps_lock <= ~caps_lock;
                            default: ;
                        endcase
                    end
                    EXT: state <= (key_data == 8'hF0) ? EXT_BRK : IDLE;
                    BRK: begin
                        if (key_data == 8'h12) shift_l <= 1'b0;
                        if (key_data == 8'h59) shift_r <= 1'b0;
                        state <= IDLE;
                    end
                    EXT_BRK: state <= IDLE;
                    IGN: begin
                        ign_cnt <= ign_cnt - 3'd1;
                        if (ign_cnt == 3'd1) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // When full, wr_ptr equals rd_ptr, so a push with pop overwrites the
    // slot that is leaving in the same cycle.
    always_ff @(posedge inclock) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_char;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            case ({do_push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// tb_ps2_keycode_decoder
//   Directed bench for ps2_keycode_decoder: prefixes, modifiers, mapping,
//   FIFO full/overflow/wrap and reset behaviour.
module tb_ps2_keycode_decoder;

    logic       inclock;
    logic       resetn;
    logic [7:0] key_data;
    logic       key_pressed;
    logic       ascii_ready;
    logic [7:0] ascii_data;
    logic       ascii_valid;
    logic [3:0] fifo_count;
    logic       shift_active;
    logic       caps_lock;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    ps2_keycode_decoder #(.FIFO_DEPTH_LOG2(3)) dut (
        .inclock     (inclock),
        .resetn      (resetn),
        .key_data    (key_data),
        .key_pressed (key_pressed),
        .ascii_ready (ascii_ready),
        .ascii_data  (ascii_data),
        .ascii_valid (ascii_valid),
        .fifo_count  (fifo_count),
        .shift_active(shift_active),
        .caps_lock   (caps_lock),
        .overflow    (overflow)
    );

    initial inclock = 1'b0;
    always #5 inclock = ~inclock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle key_pressed pulse; returns on the falling edge after acceptance.
    task automatic send(input logic [7:0] b);
        @(negedge inclock);
        key_data    = b;
        key_pressed = 1'b1;
        @(negedge inclock);
        key_pressed = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        @(negedge inclock);
        check(tag, {31'b0, ascii_valid}, 32'd1);
        check(tag, {24'b0, ascii_data}, {24'b0, exp});
        ascii_ready = 1'b1;
        @(negedge inclock);
        ascii_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'b0, ascii_valid}, 32'd0);
        check({tag, "_data"}, {24'b0, ascii_data}, 32'h00);
        check({tag, "_count"}, {28'b0, fifo_count}, 32'd0);
        check({tag, "_shift"}, {31'b0, shift_active}, 32'd0);
        check({tag, "_caps"}, {31'b0, caps_lock}, 32'd0);
        check({tag, "_ovf"}, {31'b0, overflow}, 32'd0);
    endtask

    initial begin
        resetn      = 1'b0;
        key_data    = 8'h00;
        key_pressed = 1'b0;
        ascii_ready = 1'b0;
        repeat (2) @(negedge inclock);
        check_reset_outputs("reset");
        resetn = 1'b1;

        // Single pulse of 'a'
        send(8'h1C);
        check("t1_valid", {31'b0, ascii_valid}, 32'd1);
        check("t1_data", {24'b0, ascii_data}, 32'h61);
        check("t1_count", {28'b0, fifo_count}, 32'd1);

        // key_pressed held for five cycles: one more entry only
        @(negedge inclock);
        key_data    = 8'h1C;
        key_pressed = 1'b1;
        repeat (5) @(negedge inclock);
        key_pressed = 1'b0;
        @(negedge inclock);
        check("t1_hold_count", {28'b0, fifo_count}, 32'd2);
        pop_check("t1_pop0", 8'h61);
        pop_check("t1_pop1", 8'h61);
        check("t1_empty", {28'b0, fifo_count}, 32'd0);

        // Shift make/break
        send(8'h12);
        check("t2_shift_on", {31'b0, shift_active}, 32'd1);
        send(8'h1C);
        send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h12);
        check("t2_shift_off", {31'b0, shift_active}, 32'd0);
        send(8'h1C);
        check("t2_count", {28'b0, fifo_count}, 32'd2);
        pop_check("t2_pop0", 8'h41);
        pop_check("t2_pop1", 8'h61);

        // Caps lock: break does not toggle
        send(8'h58); send(8'hF0); send(8'h58);
        check("t2_caps_on", {31'b0, caps_lock}, 32'd1);
        send(8'h1C);
        send(8'h59); send(8'h1C);
        check("t2_rshift", {31'b0, shift_active}, 32'd1);
        send(8'hF0); send(8'h59);
        send(8'h58);
        check("t2_caps_off", {31'b0, caps_lock}, 32'd0);
        pop_check("t2_pop2", 8'h41);
        pop_check("t2_pop3", 8'h61);

        // Extended keys, discarded break, unmapped code
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h5A);
        send(8'hF0); send(8'h29);
        send(8'h0E);
        check("t3_count", {28'b0, fifo_count}, 32'd2);
        send(8'h16);
        check("t3_idle_count", {28'b0, fifo_count}, 32'd3);
        pop_check("t3_pop0", 8'h11);
        pop_check("t3_pop1", 8'h0D);
        pop_check("t3_pop2", 8'h31);

        // Pause sequence ignored
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        check("t4_ign_count", {28'b0, fifo_count}, 32'd0);
        send(8'h16);
        check("t4_count", {28'b0, fifo_count}, 32'd1);
        pop_check("t4_pop", 8'h31);

        // Fill and overflow: a..i, 'i' dropped
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
        send(8'h2B); send(8'h34); send(8'h33); send(8'h43);
        check("t5_full_count", {28'b0, fifo_count}, 32'd8);
        check("t5_ovf", {31'b0, overflow}, 32'd1);
        check("t5_head", {24'b0, ascii_data}, 32'h61);

        // Push 'j' with simultaneous pop while full
        @(negedge inclock);
        key_data    = 8'h3B;
        key_pressed = 1'b1;
        ascii_ready = 1'b1;
        @(negedge inclock);
        key_pressed = 1'b0;
        ascii_ready = 1'b0;
        check("t5_pushpop_count", {28'b0, fifo_count}, 32'd8);
        pop_check("t5_d0", 8'h62);
        pop_check("t5_d1", 8'h63);
        pop_check("t5_d2", 8'h64);
        pop_check("t5_d3", 8'h65);
        pop_check("t5_d4", 8'h66);
        pop_check("t5_d5", 8'h67);
        pop_check("t5_d6", 8'h68);
        pop_check("t5_d7", 8'h6A);
        check("t5_empty_valid", {31'b0, ascii_valid}, 32'd0);
        check("t5_empty_count", {28'b0, fifo_count}, 32'd0);
        check("t5_ovf_sticky", {31'b0, overflow}, 32'd1);

        // Ready while empty is ignored
        @(negedge inclock);
        ascii_ready = 1'b1;
        @(negedge inclock);
        ascii_ready = 1'b0;
        check("t5_ready_empty", {28'b0, fifo_count}, 32'd0);

        // Reset mid-sequence flushes FIFO and loses the break prefix
        send(8'h12);
        send(8'h1C);
        send(8'hF0);
        @(negedge inclock);
        resetn = 1'b0;
        @(negedge inclock);
        check_reset_outputs("t6_rst");
        resetn = 1'b1;
        send(8'h1C);
        check("t6_count", {28'b0, fifo_count}, 32'd1);
        check("t6_data", {24'b0, ascii_data}, 32'h61);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_keycode_decoder.md
Name: ps2_keycode_decoder

Overview:
- Sits directly downstream of the PS/2 byte receiver and consumes its per-byte strobe and byte.
- Tracks the set-2 prefix sequence (E0 extended, F0 break, E1 pause), the shift and caps-lock state, and the mapping from make codes to ASCII.
- Buffers the decoded characters in a small FIFO that the Logo command-line input logic pops with a valid/ready handshake.

Parameters:
- FIFO_DEPTH_LOG2, 3: log2 of the FIFO depth (default depth 8 entries).

Ports:
- inclock  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  synchronous active-low reset.
- key_data  in  8  scan-code byte from the receiver.
- key_pressed  in  1  byte-available indication from the receiver; it may be held high for more than one cycle.
- ascii_ready  in  1  consumer pops the head entry.
- ascii_data  out  8  head-of-FIFO character; meaningful only when ascii_valid is high.
- ascii_valid  out  1  FIFO non-empty.
- fifo_count  out  FIFO_DEPTH_LOG2+1  current occupancy.
- shift_active  out  1  left or right shift currently held.
- caps_lock  out  1  caps-lock toggle state.
- overflow  out  1  sticky flag: a character was dropped because the FIFO was full.

Behaviour:
- Reset (resetn=0 at a clock edge): FSM=IDLE, FIFO emptied, ascii_valid=0, ascii_data=0x00, fifo_count=0, shift_active=0, caps_lock=0, overflow=0, edge-detect register=0, ignore counter=0. Reset wins over every other event in that cycle, including a mid-sequence prefix or a simultaneous push.
- Byte acceptance: a byte is taken only in a cycle where key_pressed=1 and the registered previous key_pressed=0. Holding key_pressed high yields exactly one acceptance.
- FSM (transitions occur on accepted bytes only):
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> IGN (counter=7); any other byte is a base make code, is processed, and the FSM stays in IDLE.
  - EXT: F0 -> EXT_BRK; any other byte is an extended make code, processed, then -> IDLE.
  - BRK: the byte is a base break code -> IDLE.
  - EXT_BRK: the byte is an extended break code -> IDLE.
  - IGN: decrement the counter on each accepted byte; -> IDLE when the counter reaches 0. No pushes and no state changes while in IGN.
- Modifiers:
  - Make 0x12 or 0x59 sets the corresponding left/right shift bit; break 0x12 or 0x59 clears it.
  - shift_active is the OR of the two bits.
  - Make 0x58 toggles caps_lock; break 0x58 has no effect.
  - Modifier codes never push.
- Base mapping (make codes only):
  - Letters: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z. Uppercase when shift_active XOR caps_lock, otherwise lowercase.
  - Digits (unaffected by shift): 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - Others: 29 -> 0x20, 5A -> 0x0D, 66 -> 0x08, 4E '-', 49 '.', 54 '[', 5B ']'.
- Extended mapping: E0 75 -> 0x11, E0 72 -> 0x12, E0 6B -> 0x13, E0 74 -> 0x14, E0 5A -> 0x0D.
- Unmapped make codes and all break codes are discarded without affecting any flags.
- Latency: a mapped byte accepted in cycle N is written at the end of cycle N. The entry is visible no earlier than cycle N+1 (ascii_valid=1 if it is the only entry), and fifo_count increments in N+1.
- Typematic repeat: repeated make codes without an intervening break each push again.
- FIFO (first-word-fall-through):
  - ascii_data always shows the head entry.
  - A pop occurs when ascii_valid and ascii_ready are both high in the same cycle. ascii_ready while empty is ignored.
  - Push with pop in the same cycle is always accepted, including when full; fifo_count is unchanged.
  - Push when full with no pop: the character is dropped, overflow is set, and FIFO contents are unchanged.
  - Read and write pointers wrap modulo the depth.
  - overflow is cleared only by reset.

Test Plan:
- Reset, then key_pressed pulse with 0x1C, ascii_ready=0 -> ascii_valid=1 one cycle later, ascii_data=0x61, fifo_count=1. Hold key_pressed for 5 cycles with 0x1C -> only one entry is pushed.
- Sequence 12, 1C, F0 1C, F0 12, 1C -> FIFO holds 0x41, 0x61. Then 58, F0 58, 1C -> 0x41 and caps_lock=1. Then 12, 1C -> 0x61.
- Sequence E0 75, E0 F0 75, E0 5A, F0 29, 0x0E (unmapped) -> FIFO holds exactly 0x11, 0x0D and the FSM ends in IDLE.
- Sequence E1 14 77 E1 F0 14 F0 77, then 16 -> only 0x31 is pushed.
- Push 9 mapped keys with ascii_ready=0 -> fifo_count=8, overflow=1, head=first key. Then ascii_ready=1 while pushing a new key in the same cycle -> count stays 8. Drain all entries -> order matches input order with the 9th key missing; pointers wrap correctly.
- Send F0, assert resetn=0 for one cycle, then send 1C -> 0x61 is pushed (break prefix lost), and all outputs equal their reset values during the reset cycle.
